// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the add-shift multiplier controller.
//   mult_state_t  - controller state encoding (IDLE, CLR, ADD, SHIFT, HOLD)
//   MULT_N_BITS   - default operand width
//   cnt_width()   - iteration counter width for a given operand width
package mult_pkg;

  localparam int MULT_N_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

  // The counter must hold 0..n-1; keep at least one bit so n=1 and n=2 still
  // get a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt: iteration counter for the add-shift multiplier.
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - synchronous, active-high; forces count to 0
//   clear    - synchronous clear to 0
//   incr     - advance by one (ignored at the terminal count, so never wraps)
//   terminal - count equals N_BITS-1 (last iteration)
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic incr,
  output logic terminal
);

  localparam int W = cnt_width(N_BITS);

  logic [W-1:0] count;

  assign terminal = (count == W'(N_BITS - 1));

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (incr && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing FSM for the N-bit signed add-shift multiplier.
// Drives the A/X/B register controls and the adder add/subtract selects,
// consuming the multiplier LSB (M) fed back from register B.
//
// Ports:
//   Clk          - system clock, FSM updates on rising edge
//   Reset        - synchronous, active-high
//   Run          - start request (level); must return to 0 before a new run
//   ClearA_LoadB - user request to clear A/X and load B (IDLE only)
//   M            - LSB of register B
//   Clr_Ld       - clear A/X and load B
//   Clr_XA       - clear A and X at start of a run
//   Add          - load A/X with A + S
//   Sub          - load A/X with A - S (last iteration, sign weight)
//   Shift_En     - arithmetic right shift of X:A:B
//   Busy         - run in progress
//   Done         - product valid, waiting for Run release
//
// Build option: MULT_CTRL_SKIP_ADD_EN - when defined, iterations with M=0
// skip the ADD cycle and go straight to SHIFT.
//
// state | meaning
// IDLE  | waiting for Run; services ClearA_LoadB
// CLR   | clear A and X, reset iteration count
// ADD   | conditional add (or subtract on the last iteration)
// SHIFT | shift X:A:B right, advance or finish
// HOLD  | product valid until Run drops
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_XA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  mult_state_t state_q, state_d;
  logic        cnt_clear;
  logic        cnt_incr;
  logic        last_iter;

  mult_iter_cnt #(.N_BITS(N_BITS)) u_iter_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (cnt_clear),
    .incr     (cnt_incr),
    .terminal (last_iter)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    Clr_Ld    = 1'b0;
    Clr_XA    = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Run takes priority over a simultaneous clear/load request.
        if (Run) begin
          state_d = CLR;
        end else if (ClearA_LoadB) begin
          Clr_Ld = 1'b1;
        end
      end

      CLR: begin
        Clr_XA    = 1'b1;
        Busy      = 1'b1;
        cnt_clear = 1'b1;
`ifdef MULT_CTRL_SKIP_ADD_EN
        state_d = M ? ADD : SHIFT;
`else
        state_d = ADD;
`endif
      end

      ADD: begin
        Busy = 1'b1;
        // The top multiplier bit carries negative weight, so it subtracts.
        if (M) begin
          if (last_iter) begin
            Sub = 1'b1;
          end else begin
            Add = 1'b1;
          end
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (last_iter) begin
          state_d = HOLD;
        end else begin
          cnt_incr = 1'b1;
          // M here is already the next B bit: B shifted on the falling edge.
`ifdef MULT_CTRL_SKIP_ADD_EN
          state_d = M ? ADD : SHIFT;
`else
          state_d = ADD;
`endif
        end
      end

      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed self-checking bench for mult_ctrl (N_BITS=8).
// Honours MULT_CTRL_SKIP_ADD_EN when the design is built with it.
module tb_mult_ctrl;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Clr_Ld, Clr_XA, Add, Sub, Shift_En, Busy, Done;
  logic [6:0] outs;

  int total = 0;
  int bad   = 0;

  assign outs = {Clr_Ld, Clr_XA, Add, Sub, Shift_En, Busy, Done};

  mult_ctrl #(.N_BITS(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Clr_XA       (Clr_XA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Expected cycles from Run sampled to Done, given popcount of B.
  function automatic int exp_latency(input int pop);
`ifdef MULT_CTRL_SKIP_ADD_EN
    return 1 + 8 + pop;
`else
    return 17;
`endif
  endfunction

  // Plays the B register: M follows bpat, shifting on each Shift_En.
  // Called from a negedge with the FSM in IDLE. Returns at the first
  // negedge showing Done (lat = edges after Run was sampled) or lat=-1.
  task automatic do_run(input logic [7:0] bpat, input bit hold_run,
                        output int n_clr, output int n_add, output int n_sub,
                        output int n_shift, output int n_busy, output int lat,
                        output int n_rule);
    int idx;
    idx = 0; n_clr = 0; n_add = 0; n_sub = 0; n_shift = 0; n_busy = 0;
    n_rule = 0; lat = -1;
    M = bpat[0];
    Run = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1 && !hold_run) Run = 1'b0;
      if (Done) begin
        lat = c - 1;
        break;
      end
      if (Clr_XA) n_clr++;
      if (Busy) n_busy++;
      if (Add) n_add++;
      if (Sub) n_sub++;
      if (Add && Sub) n_rule++;
      if (Add && (idx == 7 || !M)) n_rule++;
      if (Sub && (idx != 7 || !M)) n_rule++;
      if (Shift_En) begin
        n_shift++;
        idx++;
        M = (idx < 8) ? bpat[idx] : 1'b0;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (Done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
    step(); step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL reset_outs: got %b want 0000000", outs);
    end
    Reset = 1'b0;
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL idle_outs: got %b want 0000000", outs);
    end
  endtask

  task automatic test_clear_load();
    bit ok;
    ClearA_LoadB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (outs !== 7'b1000000) begin
        bad++; $display("FAIL clr_ld_held[%0d]: got %b want 1000000", i, outs);
      end
    end
    ClearA_LoadB = 1'b0;
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL clr_ld_release: got %b want 0000000", outs);
    end
    Run = 1'b1; ClearA_LoadB = 1'b1; M = 1'b0;
    #1;
    total++;
    if (Clr_Ld !== 1'b0) begin
      bad++; $display("FAIL run_wins_idle: Clr_Ld got %b want 0", Clr_Ld);
    end
    step();
    total++;
    if (outs !== 7'b0100010) begin
      bad++; $display("FAIL run_wins_clr: got %b want 0100010", outs);
    end
    Run = 1'b0; ClearA_LoadB = 1'b0;
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL run_wins_done: got timeout want Done");
    end
    step();
  endtask

  task automatic test_run_pattern(input string name, input logic [7:0] bpat,
                                  input int exp_add, input int exp_sub,
                                  input int pop);
    int n_clr, n_add, n_sub, n_shift, n_busy, lat, n_rule, el;
    el = exp_latency(pop);
    do_run(bpat, 1'b0, n_clr, n_add, n_sub, n_shift, n_busy, lat, n_rule);
    total++;
    if (lat != el) begin
      bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, el);
    end
    total++;
    if (n_clr != 1) begin
      bad++; $display("FAIL %s_clr_xa: got %0d want 1", name, n_clr);
    end
    total++;
    if (n_add != exp_add) begin
      bad++; $display("FAIL %s_add: got %0d want %0d", name, n_add, exp_add);
    end
    total++;
    if (n_sub != exp_sub) begin
      bad++; $display("FAIL %s_sub: got %0d want %0d", name, n_sub, exp_sub);
    end
    total++;
    if (n_shift != 8) begin
      bad++; $display("FAIL %s_shift: got %0d want 8", name, n_shift);
    end
    total++;
    if (n_busy != el) begin
      bad++; $display("FAIL %s_busy: got %0d want %0d", name, n_busy, el);
    end
    total++;
    if (n_rule != 0) begin
      bad++; $display("FAIL %s_addsub_rule: got %0d violations want 0", name, n_rule);
    end
    total++;
    if (outs !== 7'b0000001) begin
      bad++; $display("FAIL %s_done_outs: got %b want 0000001", name, outs);
    end
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL %s_back_idle: got %b want 0000000", name, outs);
    end
  endtask

  task automatic test_run_held();
    int n_clr, n_add, n_sub, n_shift, n_busy, lat, n_rule;
    bit ok;
    do_run(8'hFF, 1'b1, n_clr, n_add, n_sub, n_shift, n_busy, lat, n_rule);
    total++;
    if (lat != exp_latency(8)) begin
      bad++; $display("FAIL held_latency: got %0d want %0d", lat, exp_latency(8));
    end
    for (int i = 0; i < 20; i++) begin
      ClearA_LoadB = (i >= 5 && i < 9);
      step();
      total++;
      if (outs !== 7'b0000001) begin
        bad++; $display("FAIL held_hold[%0d]: got %b want 0000001", i, outs);
      end
    end
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL held_release: got %b want 0000000", outs);
    end
    Run = 1'b1; M = 1'b0;
    step();
    total++;
    if (outs !== 7'b0100010) begin
      bad++; $display("FAIL held_restart: got %b want 0100010", outs);
    end
    Run = 1'b0;
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL held_restart_done: got timeout want Done");
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int shifts;
    bit hit;
    shifts = 0; hit = 1'b0;
    M = 1'b1;
    Run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      Run = 1'b0;
      if (Shift_En) begin
        shifts++;
        if (shifts == 4) begin
          hit = 1'b1;
          break;
        end
      end
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrun_reach_shift3: got %0d shifts want 4", shifts);
    end
    Reset = 1'b1;
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL midrun_reset_outs: got %b want 0000000", outs);
    end
    Reset = 1'b0;
    step();
    total++;
    if (outs !== 7'b0) begin
      bad++; $display("FAIL midrun_stay_idle: got %b want 0000000", outs);
    end
  endtask

  initial begin
    test_reset();
    test_clear_load();
    test_run_pattern("ones",  8'hFF, 7, 1, 8);
    test_run_pattern("zeros", 8'h00, 0, 0, 0);
    test_run_pattern("b81",   8'h81, 1, 1, 2);
    test_run_pattern("b5a",   8'h5A, 4, 0, 4);
    test_run_pattern("b80",   8'h80, 0, 1, 1);
    test_run_held();
    test_reset_mid_run();
    test_run_pattern("after_reset", 8'h3C, 4, 0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
